// File: rtl/fir_param_mac.sv
// rtl/fir_param_mac.sv - time-multiplexed parametrised FIR filter with one shared MAC
module fir_param_mac #(
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8,
  parameter int MAX_TAPS = 16,
  parameter int FRAC_W   = 7,
  localparam int AW      = $clog2(MAX_TAPS),
  localparam int CFG_W   = (COEF_W > AW) ? COEF_W : AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [AW:0]       cfg_addr,
  input  logic [CFG_W-1:0]  cfg_data,
  output logic              cfg_err,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        ovf_flag
);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = PW + AW;
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(2 ** (FRAC_W - 1));
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
  // Bitwise inverse of 2^(n-1)-1 is -2^(n-1) in two's complement.
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_SAT, S_HOLD} state_t;

  state_t                   state_q, state_d;
  logic signed [DATA_W-1:0] x_q [MAX_TAPS];
  logic signed [COEF_W-1:0] h_q [MAX_TAPS];
  logic [AW-1:0]            nt_q, k_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic [DATA_W-1:0]        data_out_q;
  logic [1:0]               ovf_q;
  logic                     cfg_err_q;

  logic                     is_idle, accept, flush_en, cfg_ok;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  prod_ext, rnd_sum, r;
  logic [DATA_W-1:0]        sat_data;
  logic [1:0]               sat_flag;

  assign is_idle   = (state_q == S_IDLE);
  // flush has priority over a sample arriving in the same cycle.
  assign accept    = is_idle && in_valid && !flush;
  assign flush_en  = is_idle && flush;
  // Writes land only between computations; coefficient addresses past the
  // delay-line depth are treated as dropped too.
  assign cfg_ok    = is_idle && (cfg_addr[AW] || (32'(cfg_addr[AW-1:0]) < MAX_TAPS));

  assign out_valid = (state_q == S_HOLD);
  assign data_out  = data_out_q;
  assign ovf_flag  = ovf_q;
  assign cfg_err   = cfg_err_q;

  // Shared multiplier, rounding and saturation of the finished accumulator
  always_comb begin
    prod     = x_q[k_q] * h_q[k_q];
    prod_ext = {{AW{prod[PW-1]}}, prod};
    rnd_sum  = acc_q + RND;
    r        = rnd_sum >>> FRAC_W;
    sat_data = r[DATA_W-1:0];
    sat_flag = 2'b00;
    if (r > SAT_MAX) begin
      sat_data = {1'b0, {(DATA_W-1){1'b1}}};
      sat_flag = 2'b01;
    end else if (r < SAT_MIN) begin
      sat_data = {1'b1, {(DATA_W-1){1'b0}}};
      sat_flag = 2'b10;
    end
  end

  // Next-state logic and input handshake
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = !flush;
        if (in_valid && !flush) state_d = S_MAC;
      end
      S_MAC:   if (k_q == nt_q) state_d = S_SAT;
      S_SAT:   state_d = S_HOLD;
      S_HOLD:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Delay line, coefficients, tap count, accumulator and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_TAPS; i++) begin
        x_q[i] <= '0;
        h_q[i] <= '0;
      end
      nt_q       <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      data_out_q <= '0;
      ovf_q      <= 2'b00;
      cfg_err_q  <= 1'b0;
    end else begin
      cfg_err_q <= cfg_wr && !cfg_ok;
      if (cfg_wr && cfg_ok) begin
        if (cfg_addr[AW]) begin
          nt_q <= (32'(cfg_data) >= MAX_TAPS) ? AW'(MAX_TAPS - 1) : cfg_data[AW-1:0];
        end else begin
          h_q[cfg_addr[AW-1:0]] <= cfg_data[COEF_W-1:0];
        end
      end
      // The whole line shifts even past NT so a larger tap count later sees real history.
      if (flush_en) begin
        for (int i = 0; i < MAX_TAPS; i++) x_q[i] <= '0;
      end else if (accept) begin
        for (int i = MAX_TAPS - 1; i > 0; i--) x_q[i] <= x_q[i-1];
        x_q[0] <= data_in;
      end
      if (accept) begin
        acc_q <= '0;
        k_q   <= '0;
      end
      if (state_q == S_MAC) begin
        acc_q <= acc_q + prod_ext;
        k_q   <= k_q + 1'b1;
      end
      if (state_q == S_SAT) begin
        data_out_q <= sat_data;
        ovf_q      <= sat_flag;
      end
    end
  end
endmodule
